imem_loader: RTL

Boot-time writer for the 128-byte little-endian instruction memory. Accepts a byte stream over a valid/ready handshake and assembles each group of 4 bytes into a 32-bit word, first byte in bits [7:0]. Issues word writes to the memory's write port and holds the CPU core in reset until a complete image has loaded. Sits between the host/debug byte link and the instruction memory.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and memory-write bundle for imem_loader.
// master = host side that drives the byte link; slave = the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    modport master (
        output s_valid, s_data, restart,
        input  s_ready, mem_we, mem_waddr, mem_wdata, busy, done, err, cpu_hold
    );

    modport slave (
        input  s_valid, s_data, restart,
        output s_ready, mem_we, mem_waddr, mem_wdata, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into little-endian words for the
// instruction memory and holds the core in reset until the image is complete.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned ADDR_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    imem_loader_if.slave     bus
);

    localparam int unsigned WORDS = MEM_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic              s_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [31:0]       mem_wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cpu_hold_q;
    logic [IDX_W-1:0]  len_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       data_q;      // lanes 0..2 of the word being assembled
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    // s_ready_q is 1 in every state that accepts bytes, so s_valid alone marks a handshake there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            s_ready_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_hold_q  <= 1'b1;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            data_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.s_valid) begin
                        if (bus.s_data == 8'd0 || bus.s_data > 8'(WORDS)) begin
                            state_q    <= S_ERR;
                            s_ready_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            cpu_hold_q <= 1'b1;
                        end else begin
                            state_q    <= S_DATA;
                            len_q      <= IDX_W'(bus.s_data);
                            word_idx_q <= '0;
                            byte_cnt_q <= '0;
                            busy_q     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum_q      <= bus.s_data;
`endif
                        end
                    end
                end

                S_DATA: begin
                    if (bus.s_valid) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q      <= sum_q + bus.s_data;
`endif
                        case (byte_cnt_q)
                            2'd0: data_q[7:0]   <= bus.s_data;
                            2'd1: data_q[15:8]  <= bus.s_data;
                            2'd2: data_q[23:16] <= bus.s_data;
                            2'd3: begin
                                // Fourth lane completes the word: write it out next cycle
                                mem_we_q    <= 1'b1;
                                mem_waddr_q <= {word_idx_q[ADDR_W-3:0], 2'b00};
                                mem_wdata_q <= {bus.s_data, data_q};
                                word_idx_q  <= word_idx_q + IDX_W'(1);
                                if (word_idx_q == len_q - IDX_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state_q    <= S_CHECK;
`else
                                    state_q    <= S_DONE;
                                    s_ready_q  <= 1'b0;
                                    busy_q     <= 1'b0;
                                    done_q     <= 1'b1;
                                    cpu_hold_q <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end

                S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (bus.s_valid) begin
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if ((sum_q + bus.s_data) == 8'h00) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            cpu_hold_q <= 1'b1;
                        end
                    end
`else
                    state_q <= S_IDLE;
`endif
                end

                S_DONE, S_ERR: begin
                    if (bus.restart) begin
                        state_q    <= S_IDLE;
                        s_ready_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        cpu_hold_q <= 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cpu_hold  = cpu_hold_q;

endmodule
